// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: drives a KS0066/HD44780 16x2 character LCD over an 8-bit write-only bus.
// After power-up it runs the init sequence, then repeatedly writes LineA and LineB.
// Optional build macro LCD_CHANGE_SKIP_EN: skip frames whose text equals the last snapshot.
module lcd_frame_writer #(
  parameter longint unsigned M_FREQ       = 1,
  parameter int unsigned     InsWaitTime  = 10,
  parameter int unsigned     DataWaitTime = 10,
  parameter int unsigned     RefreshTime  = 320,
  parameter int unsigned     EWidth       = 2
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic [127:0] LineA,
  input  logic [127:0] LineB,
  output logic [7:0]   DB,
  output logic         RS,
  output logic         E,
  output logic         RW,
  output logic         frame_done
);

  localparam logic [31:0] PwrCycles = 32'(M_FREQ / 50 + 64'(InsWaitTime));
  localparam logic [31:0] InsWait   = 32'(InsWaitTime);
  localparam logic [31:0] ClearWait = 32'(64 * InsWaitTime);
  localparam logic [31:0] DataWait  = 32'(DataWaitTime);
  localparam logic [31:0] Refresh   = 32'(RefreshTime);
  localparam logic [31:0] EHigh     = 32'(EWidth);

  typedef enum logic [2:0] {
    StPwrWait, StInit, StAddrA, StDataA, StAddrB, StDataB, StIdle
  } state_e;

  typedef enum logic [1:0] {PhSetup, PhEHigh, PhHold, PhWait} phase_e;

  state_e       st_q, st_d;
  phase_e       ph_q, ph_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] snap_a_q, snap_a_d;
  logic [127:0] snap_b_q, snap_b_d;
  logic [7:0]   db_q, db_d;
  logic         rs_q, rs_d;

  logic [7:0]   cur_byte;
  logic         cur_rs;
  logic [31:0]  wait_len;
  logic         in_write;
  logic         write_done;
  logic [127:0] row_sel;
  logic [127:0] char_row;
  logic         load_snap;

  // Decode the byte, register select and post-write wait for the current write.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    in_write = 1'b0;
    row_sel  = (st_q == StDataB) ? snap_b_q : snap_a_q;
    // Char i sits at [127-8i -: 8]; shifting left by 8i brings it to the top byte.
    char_row = row_sel << {idx_q, 3'b000};
    case (st_q)
      StInit: begin
        in_write = 1'b1;
        case (idx_q)
          4'd0:    cur_byte = 8'h38;
          4'd1:    cur_byte = 8'h0C;
          4'd2:    cur_byte = 8'h01;
          default: cur_byte = 8'h06;
        endcase
      end
      StAddrA: begin
        in_write = 1'b1;
        cur_byte = 8'h80;
      end
      StAddrB: begin
        in_write = 1'b1;
        cur_byte = 8'hC0;
      end
      StDataA, StDataB: begin
        in_write = 1'b1;
        cur_byte = char_row[127:120];
        cur_rs   = 1'b1;
      end
      default: ;
    endcase
    if (cur_rs) begin
      wait_len = DataWait;
    end else if (cur_byte == 8'h01) begin
      wait_len = ClearWait;  // clear display needs a much longer settle time
    end else begin
      wait_len = InsWait;
    end
    write_done = in_write && (ph_q == PhWait) && (cnt_q == wait_len - 32'd1);
  end

  // Next-state logic for the write engine and the frame sequencer.
  always_comb begin
    st_d      = st_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_a_d  = snap_a_q;
    snap_b_d  = snap_b_q;
    db_d      = db_q;
    rs_d      = rs_q;
    load_snap = 1'b0;

    if (in_write) begin
      unique case (ph_q)
        PhSetup: begin
          ph_d  = PhEHigh;
          cnt_d = 32'd0;
          db_d  = cur_byte;
          rs_d  = cur_rs;
        end
        PhEHigh: begin
          if (cnt_q == EHigh - 32'd1) begin
            ph_d  = PhHold;
            cnt_d = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        PhHold: begin
          ph_d  = PhWait;
          cnt_d = 32'd0;
        end
        PhWait: begin
          if (write_done) begin
            ph_d  = PhSetup;
            cnt_d = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      endcase
    end

    case (st_q)
      StPwrWait: begin
        if (cnt_q == PwrCycles - 32'd1) begin
          st_d  = StInit;
          cnt_d = 32'd0;
          idx_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StInit: begin
        if (write_done) begin
          if (idx_q == 4'd3) begin
            st_d      = StAddrA;
            load_snap = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StAddrA: begin
        if (write_done) begin
          st_d  = StDataA;
          idx_d = 4'd0;
        end
      end
      StDataA: begin
        if (write_done) begin
          if (idx_q == 4'd15) st_d = StAddrB;
          else                idx_d = idx_q + 4'd1;
        end
      end
      StAddrB: begin
        if (write_done) begin
          st_d  = StDataB;
          idx_d = 4'd0;
        end
      end
      StDataB: begin
        if (write_done) begin
          if (idx_q == 4'd15) begin
            st_d  = StIdle;
            cnt_d = 32'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StIdle: begin
        if (cnt_q == Refresh - 32'd1) begin
          cnt_d = 32'd0;
`ifdef LCD_CHANGE_SKIP_EN
          // Unchanged text: stay idle and restart the refresh count.
          if ({LineA, LineB} != {snap_a_q, snap_b_q}) begin
            st_d      = StAddrA;
            load_snap = 1'b1;
          end
`else
          st_d      = StAddrA;
          load_snap = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: st_d = StPwrWait;
    endcase

    if (load_snap) begin
      snap_a_d = LineA;
      snap_b_d = LineB;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge mclk) begin
    if (rst) begin
      st_q     <= StPwrWait;
      ph_q     <= PhSetup;
      cnt_q    <= 32'd0;
      idx_q    <= 4'd0;
      snap_a_q <= 128'd0;
      snap_b_q <= 128'd0;
      db_q     <= 8'h00;
      rs_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
      db_q     <= db_d;
      rs_q     <= rs_d;
    end
  end

  // Bus outputs: the new byte appears in SETUP and is held until the next SETUP.
  always_comb begin
    DB         = (in_write && ph_q == PhSetup) ? cur_byte : db_q;
    RS         = (in_write && ph_q == PhSetup) ? cur_rs : rs_q;
    E          = in_write && (ph_q == PhEHigh);
    RW         = 1'b0;
    frame_done = (st_q == StDataB) && (idx_q == 4'd15) && write_done;
  end

endmodule
